mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_ctrl_array.sv | 23 ++
 rtl/mem_ctrl.sv | 91 +++++++++
 tb/tb_mem_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the wait-state memory controller: FSM state encodings
// and the default geometry/timing parameters.
package mem_ctrl_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 10;
    localparam int DEFAULT_WAIT_STATES = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mem_ctrl_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are intentionally not reset.
module mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: accepts one read or write at a time from control, inserts
// WAIT_STATES extra cycles, then pulses done for a single cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    state_t                state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_data;
    logic                  cap_wr;
    logic                  addr_ok;
    logic                  array_we;
    logic [31:0]           array_rdata;

    assign addr_ok  = ((addr >> ADDR_WIDTH) == 32'd0);
    assign array_we = (state == WAIT) && (count == 4'd0) && cap_wr;

    mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (cap_addr),
        .wdata (cap_data),
        .rdata (array_rdata)
    );

    // Conflicting or out-of-range requests skip WAIT entirely and report via fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            cap_addr <= '0;
            cap_data <= 32'd0;
            cap_wr   <= 1'b0;
            rd_data  <= 32'd0;
            fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_rd || mem_wr) begin
                        cap_addr <= addr[ADDR_WIDTH-1:0];
                        cap_data <= wr_data;
                        cap_wr   <= mem_wr;
                        count    <= 4'(WAIT_STATES);
                        if ((mem_rd && mem_wr) || !addr_ok) begin
                            fault <= 1'b1;
                            state <= DONE;
                        end else begin
                            fault <= 1'b0;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!cap_wr) begin
                            rd_data <= array_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: one instance with WAIT_STATES=0 and one with 2,
// sharing clock and reset.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        fault_s [2];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
        .clk     (clk),
        .rst     (rst),
        .mem_rd  (rd_s[0]),
        .mem_wr  (wr_s[0]),
        .addr    (addr_s[0]),
        .wr_data (wdata_s[0]),
        .rd_data (rdata_s[0]),
        .busy    (busy_s[0]),
        .done    (done_s[0]),
        .fault   (fault_s[0])
    );

    mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_ws2 (
        .clk     (clk),
        .rst     (rst),
        .mem_rd  (rd_s[1]),
        .mem_wr  (wr_s[1]),
        .addr    (addr_s[1]),
        .wr_data (wdata_s[1]),
        .rd_data (rdata_s[1]),
        .busy    (busy_s[1]),
        .done    (done_s[1]),
        .fault   (fault_s[1])
    );

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rd  [2];
    int          ws        [2] = '{0, 2};
    int          checks = 0;
    int          fails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, pushes the expected outcome, then pops it when done rises.
    // Edge 1 is the accepting edge, so valid requests finish on edge WAIT_STATES+2.
    task automatic applyStimulus(input int u, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d, input bit perturb);
        exp_t e;
        exp_t got;
        int   edges;
        bit   flt;
        @(negedge clk);
        rd_s[u]    = rd;
        wr_s[u]    = wr;
        addr_s[u]  = a;
        wdata_s[u] = d;
        flt = (rd && wr) || ((a >> 10) != 32'd0);
        if (!flt && wr) model_mem[u * 4096 + int'(a)] = d;
        if (!flt && rd) model_rd[u] = model_mem[u * 4096 + int'(a)];
        e.rd    = model_rd[u];
        e.fault = flt;
        e.lat   = flt ? 1 : ws[u] + 2;
        sb.push_back(e);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                rd_s[u] = 1'b0;
                wr_s[u] = 1'b0;
                if (perturb) begin
                    addr_s[u]  = a + 32'd1;
                    wdata_s[u] = ~d;
                end
            end
        end while (!done_s[u] && edges < 40);
        got = sb.pop_front();
        checkOutput("done_seen", 32'(done_s[u]), 32'd1);
        checkOutput("latency", 32'(edges), 32'(got.lat));
        checkOutput("rd_data", rdata_s[u], got.rd);
        checkOutput("fault", 32'(fault_s[u]), 32'(got.fault));
        checkOutput("busy_in_done", 32'(busy_s[u]), 32'd1);
        if (perturb) rd_s[u] = 1'b1;
        @(posedge clk);
        #1;
        rd_s[u] = 1'b0;
        checkOutput("done_one_cycle", 32'(done_s[u]), 32'd0);
        checkOutput("busy_idle", 32'(busy_s[u]), 32'd0);
        if (perturb) begin
            @(posedge clk);
            #1;
            checkOutput("no_extra_access", 32'(busy_s[u]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'd0; wdata_s[i] = 32'd0;
            model_rd[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_busy", 32'(busy_s[i]), 32'd0);
            checkOutput("reset_done", 32'(done_s[i]), 32'd0);
            checkOutput("reset_fault", 32'(fault_s[i]), 32'd0);
            checkOutput("reset_rd_data", rdata_s[i], 32'd0);
        end
        rst = 1'b0;

        // Write then read with two wait states.
        applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Zero wait states.
        applyStimulus(0, 1'b0, 1'b1, 32'h3, 32'h12345678, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h3, 32'h0, 1'b0);

        // Conflicting request leaves array and rd_data alone.
        applyStimulus(1, 1'b0, 1'b1, 32'h5, 32'hCAFEF00D, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 32'h5, 32'h55555555, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0);

        // Out-of-range write must not alias onto word 0; fault is sticky until next accept.
        applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'h0000AAAA, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("fault_sticky", 32'(fault_s[1]), 32'd1);
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset in the first WAIT cycle aborts the pending write.
        applyStimulus(1, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
        @(negedge clk);
        wr_s[1] = 1'b1; addr_s[1] = 32'h20; wdata_s[1] = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        wr_s[1] = 1'b0;
        checkOutput("busy_after_accept", 32'(busy_s[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;
        checkOutput("abort_busy", 32'(busy_s[1]), 32'd0);
        checkOutput("abort_done", 32'(done_s[1]), 32'd0);
        checkOutput("abort_rd_data", rdata_s[1], 32'd0);
        checkOutput("abort_rd_data_ws0", rdata_s[0], 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Inputs changed after acceptance and a read pulse during DONE are ignored.
        applyStimulus(1, 1'b0, 1'b1, 32'h41, 32'h41414141, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'h77777777, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h41, 32'h0, 1'b0);

        // A request held high is re-accepted on the first IDLE edge.
        @(negedge clk);
        rd_s[0] = 1'b1; addr_s[0] = 32'h3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("b2b_done1", 32'(done_s[0]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_idle", 32'(busy_s[0]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b_reaccept", 32'(busy_s[0]), 32'd1);
        rd_s[0] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b_done2", 32'(done_s[0]), 32'd1);
        checkOutput("b2b_rd_data", rdata_s[0], model_mem[3]);
        @(posedge clk);
        #1;

        // Randomised write/read-back pairs.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rdat;
            ra   = 32'h80 + 32'($urandom_range(0, 7));
            rdat = $urandom;
            applyStimulus(1, 1'b0, 1'b1, ra, rdat, 1'b0);
            applyStimulus(1, 1'b1, 1'b0, ra, 32'h0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
